// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 when UART_RX_PARITY_EN is defined), LSB first, mid-bit sampling.
// Each byte is presented with a one-cycle data_en strobe; a low stop bit gives a frame_err strobe.
module uart_rx #(
  parameter int CLK_FREQ_KHz  = 50000,
  parameter int BAUD_RATE_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_en,
  output logic       rx_busy,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int BIT_CLOCKS  = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS;
  localparam int HALF_CLOCKS = BIT_CLOCKS / 2;
  localparam int CNT_W       = (BIT_CLOCKS > 2) ? $clog2(BIT_CLOCKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLOCKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLOCKS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_STOP   = 5'b01000,
    S_PARITY = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_DATA  = 4'b0100,
    S_STOP  = 4'b1000
  } state_t;
`endif

  state_t           state_q, state_d;
  logic             meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             data_en_q, data_en_d;
  logic             frame_err_q, frame_err_d;
  logic             bit_done, half_done;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  assign bit_done  = (cnt_q == BIT_LAST);
  assign half_done = (cnt_q == HALF_LAST);

  // State register plus datapath flops; synchroniser resets to idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      meta_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      data_en_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      meta_q       <= rx;
      rx_s_q       <= meta_q;
      rx_prev_q    <= rx_s_q;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_en_q    <= data_en_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (rx_prev_q && !rx_s_q) state_d = S_START;
      S_START:  if (half_done) state_d = rx_s_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (bit_done && bit_cnt_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_done) state_d = S_STOP;
`else
      S_DATA:   if (bit_done && bit_cnt_q == 3'd7) state_d = S_STOP;
`endif
      // Leaving at mid-stop-bit leaves half a bit to catch the next start edge
      S_STOP:   if (bit_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_en_d    = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
      end
      S_START: cnt_d = half_done ? '0 : cnt_q + 1'b1;
      S_DATA: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) par_bad_d = rx_s_q ^ (^shift_q);
      end
`endif
      S_STOP: begin
        cnt_d = bit_done ? '0 : cnt_q + 1'b1;
        if (bit_done) begin
          if (rx_s_q) begin
            data_d    = shift_q;
            data_en_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_comb begin
    rx_busy    = (state_q != S_IDLE);
    data       = data_q;
    data_en    = data_en_q;
    frame_err  = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_err = parity_err_q;
`endif
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a queue-based reference model of the received events.
// Each received strobe is recorded as an event word and matched in order against expectations.
module tb_uart_rx;
  localparam int CLK_KHZ = 1000;
  localparam int BAUD    = 100000;
  localparam int BIT     = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_en, rx_busy, frame_err;
  logic       perr_w;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  assign perr_w = parity_err;
`else
  assign perr_w = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLK_FREQ_KHz(CLK_KHZ), .BAUD_RATE_BPS(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .data_en   (data_en),
    .rx_busy   (rx_busy),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .frame_err (frame_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];
  logic [7:0]  model_data;

  // Event word: {parity_err, frame_err, data_en, byte-or-zero}
  always @(negedge clk)
    if (!rst && (data_en || frame_err || perr_w))
      got_q.push_back({perr_w, frame_err, data_en, data_en ? data : 8'h00});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_events(input string tag);
    int n;
    #1;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    logic perr;
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
      if (i == 3) check("busy_mid", rx_busy, 1'b1);
    end
`ifdef UART_RX_PARITY_EN
    rx = par_bit;
    repeat (BIT) @(negedge clk);
    perr = (par_bit != ^b);
`else
    perr = 1'b0;
`endif
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    if (stop_bit) begin
      exp_q.push_back({perr, 1'b0, 1'b1, b});
      model_data = b;
    end else begin
      exp_q.push_back({perr, 1'b1, 1'b0, 8'h00});
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rstop, rpar;
    int         gap;

    rst = 1'b1;
    rx = 1'b1;
    model_data = 8'h00;
    idle(3);
    check("rst_data", data, 8'h00);
    check("rst_data_en", data_en, 1'b0);
    check("rst_busy", rx_busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    idle(5);

    // Single good frame
    send_frame(8'hA5, 1'b1, ^8'hA5);
    rx = 1'b1;
    idle(3);
    check_events("t1");
    check("t1_data", data, model_data);
    check("t1_busy_low", rx_busy, 1'b0);

    // Back-to-back frames, no idle gap
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    rx = 1'b1;
    idle(3);
    check_events("t2");

    // Glitch shorter than half a bit: false start
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(1);
    check("t3_busy_hi", rx_busy, 1'b1);
    idle(12);
    check("t3_busy_low", rx_busy, 1'b0);
    check_events("t3");

    // Bad stop bit, then line stuck low
    send_frame(8'h55, 1'b0, ^8'h55);
    idle(40);
    check_events("t4_ferr");
    check("t4_data_hold", data, model_data);
    check("t4_busy_low", rx_busy, 1'b0);
    rx = 1'b1;
    idle(5);
    send_frame(8'h96, 1'b1, ^8'h96);
    rx = 1'b1;
    idle(3);
    check_events("t4_recover");

    // Reset during bit 4 of 0x81
    rb = 8'h81;
    rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      idle(BIT);
    end
    rx = rb[4];
    idle(BIT / 2);
    rst = 1'b1;
    #1;
    model_data = 8'h00;
    check("t5_data", data, model_data);
    check("t5_data_en", data_en, 1'b0);
    check("t5_busy", rx_busy, 1'b0);
    check("t5_frame_err", frame_err, 1'b0);
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    check_events("t5_abort");
    send_frame(8'h81, 1'b1, ^8'h81);
    rx = 1'b1;
    idle(3);
    check_events("t5_after");
    check("t5_data_after", data, model_data);

`ifdef UART_RX_PARITY_EN
    // Even parity: good and bad parity bit
    send_frame(8'h07, 1'b1, 1'b1);
    rx = 1'b1;
    idle(3);
    send_frame(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    idle(3);
    check_events("t6");
`endif

    // Randomized frames, occasional stop/parity errors, random gaps
    for (int k = 0; k < 20; k++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 7) != 0);
      rpar  = ($urandom_range(0, 3) == 0) ? ~(^rb) : ^rb;
      send_frame(rb, rstop, rpar);
      gap = rstop ? $urandom_range(0, 8) : $urandom_range(2, 8);
      rx = 1'b1;
      idle(gap);
    end
    rx = 1'b1;
    idle(3);
    check_events("rand");
    check("rand_data", data, model_data);
    check("rand_busy_low", rx_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
